// File: rtl/cache_refill_engine.sv
// cache_refill_engine: optional dirty-line writeback followed by a line refill,
// moving two words per memory beat with one request outstanding at a time.
module cache_refill_engine #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BANK_NUM   = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           miss_cache,
    input  logic [ADDR_WIDTH-1:0]          addr_cache,
    input  logic                           set_cache,
    input  logic                           need_wb,
    input  logic [ADDR_WIDTH-1:0]          addr_wb,
    input  logic [BANK_NUM*DATA_WIDTH-1:0] data_wb,
    output logic                           busy_wb,
    output logic                           busy_rd,
    output logic [ADDR_WIDTH-1:0]          addr_rd,
    output logic [2*DATA_WIDTH-1:0]        data_rd,
    output logic                           wen_rd,
    output logic                           set_rd,
    output logic                           finish_rd,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_wen,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr,
    output logic [2*DATA_WIDTH-1:0]        mem_req_wdata,
    input  logic                           mem_resp_valid,
    input  logic [2*DATA_WIDTH-1:0]        mem_resp_data
);
    localparam int BYTE_NUM = DATA_WIDTH / 8;
    localparam int BEATS    = BANK_NUM / 2;
    localparam int CW       = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int BW       = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, WB_REQ, WB_RESP, RD_REQ, RD_RESP, FINISH} state_t;

    state_t                        r_state, w_next;
    logic [CW-1:0]                 r_beat;
    logic [ADDR_WIDTH-1:0]         r_addr_rd, r_addr_wb;
    logic                          r_set;
    logic [BANK_NUM*DATA_WIDTH-1:0] r_data_wb;
    logic                          w_last, w_hit;
    logic [ADDR_WIDTH-1:0]         w_off;
    logic [BW-1:0]                 w_wdata;

    assign w_last  = r_beat == CW'(BEATS - 1);
    assign w_off   = ADDR_WIDTH'(r_beat) * ADDR_WIDTH'(2 * BYTE_NUM);
    assign w_wdata = r_data_wb[r_beat*BW +: BW];
    assign w_hit   = r_state == RD_RESP && mem_resp_valid;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = miss_cache ? (need_wb ? WB_REQ : RD_REQ) : IDLE;
            WB_REQ:  w_next = mem_req_ready ? WB_RESP : WB_REQ;
            WB_RESP: w_next = mem_resp_valid ? (w_last ? RD_REQ : WB_REQ) : WB_RESP;
            RD_REQ:  w_next = mem_req_ready ? RD_RESP : RD_REQ;
            RD_RESP: w_next = mem_resp_valid ? (w_last ? FINISH : RD_REQ) : RD_RESP;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Line addresses, way and victim data stay frozen for the whole transaction
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_beat    <= '0;
            r_addr_rd <= '0;
            r_addr_wb <= '0;
            r_set     <= 1'b0;
            r_data_wb <= '0;
        end else if (r_state == IDLE && miss_cache) begin
            r_beat    <= '0;
            r_addr_rd <= addr_cache;
            r_set     <= set_cache;
            if (need_wb) begin
                r_addr_wb <= addr_wb;
                r_data_wb <= data_wb;
            end
        end else if ((r_state == WB_RESP || r_state == RD_RESP) && mem_resp_valid) begin
            r_beat <= w_last ? '0 : r_beat + 1'b1;
        end
    end

    always_comb begin
        busy_wb       = r_state == WB_REQ || r_state == WB_RESP;
        busy_rd       = r_state != IDLE;
        mem_req_valid = r_state == WB_REQ || r_state == RD_REQ;
        mem_req_wen   = r_state == WB_REQ;
        mem_req_addr  = r_state == WB_REQ ? r_addr_wb + w_off :
                        r_state == RD_REQ ? r_addr_rd + w_off : '0;
        mem_req_wdata = r_state == WB_REQ ? w_wdata : '0;
        wen_rd        = w_hit;
        data_rd       = w_hit ? mem_resp_data : '0;
        addr_rd       = w_hit ? r_addr_rd + w_off : r_state == FINISH ? r_addr_rd : '0;
        set_rd        = (w_hit || r_state == FINISH) && r_set;
        finish_rd     = r_state == FINISH;
    end
endmodule

// File: tb/tb_cache_refill_engine.sv
// tb_cache_refill_engine: memory model plus request/refill scoreboard queues
// checked every cycle against a bench-side transaction model.
module tb_cache_refill_engine;
    localparam int BEATS = 2;
    localparam int BW    = 128;

    typedef struct {logic wen; logic [63:0] addr; logic [BW-1:0] wdata;} req_t;
    typedef struct {logic [63:0] addr; logic [BW-1:0] data; logic set;} rf_t;

    logic           clk = 0, rstn = 0;
    logic           miss_cache = 0, set_cache = 0, need_wb = 0;
    logic [63:0]    addr_cache = 0, addr_wb = 0;
    logic [255:0]   data_wb = 0;
    logic           busy_wb, busy_rd, wen_rd, set_rd, finish_rd;
    logic [63:0]    addr_rd, mem_req_addr;
    logic [BW-1:0]  data_rd, mem_req_wdata, mem_resp_data;
    logic           mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;

    cache_refill_engine dut (
        .clk(clk), .rstn(rstn), .miss_cache(miss_cache), .addr_cache(addr_cache),
        .set_cache(set_cache), .need_wb(need_wb), .addr_wb(addr_wb), .data_wb(data_wb),
        .busy_wb(busy_wb), .busy_rd(busy_rd), .addr_rd(addr_rd), .data_rd(data_rd),
        .wen_rd(wen_rd), .set_rd(set_rd), .finish_rd(finish_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_err = 0;
    req_t        q[$];
    rf_t         rq[$];
    logic        act = 0, fin = 0, outst = 0, out_rd = 0, pend = 0, spur = 0;
    int          wb_left = 0, rd_left = 0, stall = 0;
    logic [63:0] tb_line = 0;
    logic        tb_set = 0;
    logic [BW-1:0] pend_data = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        req_t r;
        rf_t  f;
        logic a0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            mem_resp_valid = pend || spur;
            mem_resp_data  = pend ? pend_data : {$urandom, $urandom, $urandom, $urandom};
            pend = 0; spur = 0;
            mem_req_ready = stall == 0;
            #1;
            a0 = act;
            chk("busy_rd", busy_rd, act);
            chk("busy_wb", busy_wb, wb_left != 0);
            chk("finish_rd", finish_rd, fin);
            chk("req_valid", mem_req_valid, act && !fin && !outst && q.size() != 0);
            chk("wen_rd", wen_rd, outst && out_rd && mem_resp_valid);
            if (!act)
                chk("idle_zero", |{addr_rd, data_rd, mem_req_addr, mem_req_wdata, mem_req_wen, set_rd}, 0);
            if (fin) begin
                chk("fin_addr", addr_rd, tb_line);
                chk("fin_set", set_rd, tb_set);
                fin = 0; act = 0;
            end
            if (outst && mem_resp_valid) begin
                outst = 0;
                if (out_rd) begin
                    if (rq.size() == 0) chk("rf_queue", 0, 1);
                    else begin
                        f = rq.pop_front();
                        chk("rf_addr", addr_rd, f.addr);
                        chk("rf_data", data_rd, f.data);
                        chk("rf_set", set_rd, f.set);
                    end
                    rd_left--;
                    if (rd_left == 0) fin = 1;
                end else wb_left--;
            end
            if (mem_req_valid && q.size() != 0) begin
                chk("req_wen", mem_req_wen, q[0].wen);
                chk("req_addr", mem_req_addr, q[0].addr);
                chk("req_wdata", mem_req_wdata, q[0].wdata);
                if (mem_req_ready) begin
                    r = q.pop_front();
                    outst = 1; out_rd = !r.wen; pend = 1;
                    pend_data = r.wen ? '0 : {$urandom, $urandom, $urandom, $urandom};
                    if (!r.wen) rq.push_back('{r.addr, pend_data, tb_set});
                end
            end
            if (mem_req_valid && !mem_req_ready && stall != 0) stall--;
            if (!a0 && miss_cache) begin
                act = 1; tb_line = addr_cache; tb_set = set_cache;
                wb_left = need_wb ? BEATS : 0; rd_left = BEATS;
                for (int b = 0; b < BEATS; b++)
                    if (need_wb) q.push_back('{1'b1, addr_wb + 64'(b * 16), data_wb[b*BW +: BW]});
                for (int b = 0; b < BEATS; b++)
                    q.push_back('{1'b0, addr_cache + 64'(b * 16), '0});
            end
            if (!rstn) begin
                act = 0; fin = 0; outst = 0; wb_left = 0; rd_left = 0;
                q.delete(); rq.delete();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (!act) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic miss(input logic [63:0] a, input logic s, input logic wb,
                        input logic [63:0] aw, input logic [255:0] dw);
        miss_cache = 1; addr_cache = a; set_cache = s; need_wb = wb; addr_wb = aw; data_wb = dw;
        cyc();
        miss_cache = 0; need_wb = 0;
    endtask

    localparam logic [255:0] DW_A = {64'hA3, 64'hA2, 64'hA1, 64'hA0};

    initial begin
        repeat (3) cyc();
        rstn = 1;
        cyc();
        spur = 1; need_wb = 1;
        cyc();
        need_wb = 0;
        repeat (2) cyc();
        miss(64'h1000, 1, 0, 0, 0);
        wait_idle();
        miss(64'h3000, 0, 1, 64'h2000, DW_A);
        wait_idle();
        stall = 5;
        miss(64'h4000, 1, 1, 64'h5000, {$urandom, $urandom, $urandom, $urandom,
                                         $urandom, $urandom, $urandom, $urandom});
        wait_idle();
        stall = 5;
        miss(64'h8000, 0, 0, 0, 0);
        wait_idle();
        miss(64'h6000, 1, 0, 0, 0);
        cyc();
        miss(64'h7000, 0, 1, 64'h9000, DW_A);
        miss(64'h7000, 0, 0, 0, 0);
        wait_idle();
        miss(64'hFFFF_FFFF_FFFF_FFF0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0, DW_A);
        wait_idle();
        miss(64'hA000, 1, 1, 64'hB000, DW_A);
        cyc();
        rstn = 0;
        cyc();
        rstn = 1;
        repeat (3) cyc();
        miss(64'hC000, 0, 0, 0, 0);
        wait_idle();
        repeat (2) cyc();
        chk("queues_empty", q.size() + rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
